// File: rtl/abacus_pkg.sv
// Shared definitions for the ABACUS event counter bank: register offsets,
// CTRL bit positions, register select codes and the INFO word layout.
package abacus_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_INFO   = 8'h08;
  localparam logic [7:0] REG_IRQMSK = 8'h0C;
  localparam logic [7:0] REG_SNAP0  = 8'h20;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_CLR  = 1;
  localparam int unsigned CTRL_SNAP = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_INFO,
    SEL_IRQMSK,
    SEL_SNAP
  } reg_sel_e;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic       saturate;
    logic [6:0] rsvd_lo;
    logic [7:0] width;
    logic [7:0] count;
  } info_t;

  function automatic logic [31:0] info_word(input int unsigned num_counters,
                                            input int unsigned counter_width,
                                            input logic saturate);
    info_t w;
    w          = '0;
    w.saturate = saturate;
    w.width    = 8'(counter_width);
    w.count    = 8'(num_counters);
    return w;
  endfunction

endpackage

// File: rtl/abacus_event_counter_bank_if.sv
// Wishbone slave bundle for the ABACUS event counter bank.
interface abacus_event_counter_bank_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack;

  modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
                  input  wb_dat_o, wb_ack);
  modport slave  (input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
                  output wb_dat_o, wb_ack);
endinterface

// File: rtl/abacus_event_counter.sv
// One counter channel: live count, snapshot copy and sticky overflow flag.
// Wraps to zero or holds at all-ones depending on SATURATE.
module abacus_event_counter #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_inc,
  input  logic                     i_clear,
  input  logic                     i_snap,
  input  logic                     i_ovf_clr,
  output logic [COUNTER_WIDTH-1:0] o_snap,
  output logic                     o_ovf
);

  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [COUNTER_WIDTH-1:0] r_snap;
  logic                     r_ovf;
  logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
  logic                     w_at_max;
  logic                     w_set;

  assign w_at_max = &r_cnt;
  // i_inc is already masked by the caller when a clear is pending
  assign w_set    = i_inc & w_at_max;

  // next count: clear beats increment; all-ones wraps or holds
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        w_cnt_nxt = SATURATE ? r_cnt : '0;
      end else begin
        w_cnt_nxt = r_cnt + COUNTER_WIDTH'(1);
      end
    end
  end

  // count, snapshot of the pre-update value, sticky overflow (set beats RW1C)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (i_snap) r_snap <= r_cnt;
      r_ovf <= i_clear ? 1'b0 : ((r_ovf & ~i_ovf_clr) | w_set);
    end
  end

  assign o_snap = r_snap;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/abacus_event_counter_bank.sv
// ABACUS profiler event counter bank with a Wishbone slave.
// Optional feature: define ABACUS_COUNTER_IRQ_EN to implement IRQMSK and the
// registered overflow interrupt; otherwise IRQMSK reads 0 and irq is tied 0.
module abacus_event_counter_bank
  import abacus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'hf0030000,
  parameter int unsigned NUM_COUNTERS  = 16,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  abacus_event_counter_bank_if.slave    wb,
  input  logic [NUM_COUNTERS-1:0]       event_i,
  output logic                          irq
);

  logic                     r_ack;
  logic [31:0]              r_dat;
  logic                     r_enable;

  logic                     w_req;
  logic                     w_wr;
  logic [7:0]               w_off;
  logic [5:0]               w_snap_idx;
  reg_sel_e                 w_sel;
  logic                     w_ctrl_wr;
  logic                     w_status_wr;
  logic                     w_clear;
  logic                     w_snap;
  logic [NUM_COUNTERS-1:0]  w_inc;
  logic [NUM_COUNTERS-1:0]  w_ovf;
  logic [NUM_COUNTERS-1:0]  w_ovf_clr;
  logic [NUM_COUNTERS-1:0]  w_mask;
  logic [31:0]              w_rdata;
  logic [COUNTER_WIDTH-1:0] w_snap_val [NUM_COUNTERS];

  assign w_off       = wb.wb_adr[7:0];
  assign w_snap_idx  = w_off[7:2] - 6'd8;
  assign w_req       = wb.wb_cyc & wb.wb_stb & ~r_ack &
                       (wb.wb_adr[31:8] == BASE_ADDR[31:8]);
  assign w_wr        = w_req & wb.wb_we;
  assign w_ctrl_wr   = w_wr & (w_sel == SEL_CTRL);
  assign w_status_wr = w_wr & (w_sel == SEL_STATUS);
  assign w_clear     = w_ctrl_wr & wb.wb_dat_i[CTRL_CLR];
  assign w_snap      = w_ctrl_wr & wb.wb_dat_i[CTRL_SNAP];
  assign w_inc       = w_clear ? '0 : (event_i & {NUM_COUNTERS{r_enable}});

  // register decode from the byte offset within the window
  always_comb begin
    w_sel = SEL_NONE;
    case (w_off)
      REG_CTRL:   w_sel = SEL_CTRL;
      REG_STATUS: w_sel = SEL_STATUS;
      REG_INFO:   w_sel = SEL_INFO;
      REG_IRQMSK: w_sel = SEL_IRQMSK;
      default:    if (w_off >= REG_SNAP0 && w_off[1:0] == 2'b00) w_sel = SEL_SNAP;
    endcase
  end

  // per-channel RW1C strobes; channels above bit 31 are not addressable
  always_comb begin
    w_ovf_clr = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (i < 32) w_ovf_clr[i] = w_status_wr & wb.wb_dat_i[i[4:0]];
    end
  end

  // read mux; snapshots are zero-extended, unmapped offsets read 0
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_CTRL:   w_rdata[CTRL_EN] = r_enable;
      SEL_STATUS: for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (i < 32) w_rdata[i[4:0]] = w_ovf[i];
                  end
      SEL_INFO:   w_rdata = info_word(NUM_COUNTERS, COUNTER_WIDTH, SATURATE);
      SEL_IRQMSK: for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (i < 32) w_rdata[i[4:0]] = w_mask[i];
                  end
      SEL_SNAP:   for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (w_snap_idx == 6'(i)) w_rdata = 32'(w_snap_val[i]);
                  end
      default:    w_rdata = '0;
    endcase
  end

  // bus handshake (one ack per accepted request) and CTRL enable bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_enable <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : '0;
      if (w_ctrl_wr) r_enable <= wb.wb_dat_i[CTRL_EN];
    end
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_dat_o = r_dat;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ch
    abacus_event_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .SATURATE      (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst),
      .i_inc     (w_inc[g]),
      .i_clear   (w_clear),
      .i_snap    (w_snap),
      .i_ovf_clr (w_ovf_clr[g]),
      .o_snap    (w_snap_val[g]),
      .o_ovf     (w_ovf[g])
    );
  end

`ifdef ABACUS_COUNTER_IRQ_EN
  logic [NUM_COUNTERS-1:0] r_mask;
  logic [NUM_COUNTERS-1:0] w_mask_wdat;
  logic                    r_irq;
  logic                    w_mask_wr;

  assign w_mask_wr = w_wr & (w_sel == SEL_IRQMSK);

  // mask write data, limited to the 32 addressable channels
  always_comb begin
    w_mask_wdat = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (i < 32) w_mask_wdat[i] = wb.wb_dat_i[i[4:0]];
    end
  end

  // mask register and registered interrupt, one cycle behind the flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_mask_wr) r_mask <= w_mask_wdat;
      r_irq <= |(w_ovf & r_mask);
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

endmodule
